led_pattern_fsm: RTL and testbench
==================================

# led_pattern_fsm

Parametrised LED pattern sequencer, the next generation of the fixed 4-LED sequencer. It drives `NUM_LEDS` outputs through one of four selectable patterns: chase, bounce, blink and fill. It advances at a programmable step rate derived from the system clock, and has a freeze control. It sits directly behind the board LED pins and is driven by mode/enable straps or a host register.

## Interface
- `NUM_LEDS`, default 4: LED count; legal range 2–32.
- `TICK_DIV`, default 4: clock cycles per pattern step; legal range ≥ 1; 1 means a step on every enabled cycle.
- `clk`, input, 1 bit: single system clock; all logic is on the rising edge.
- `reset_n`, input, 1 bit: reset is synchronous and active-low.
- `mode`, input, 2 bits: pattern select. 0 CHASE, 1 BOUNCE, 2 BLINK, 3 FILL.
- `enable`, input, 1 bit: high runs the sequencer; low freezes the prescaler and the pattern.
- `leds`, output, `NUM_LEDS` bits: registered LED drive; bit 0 is the rightmost LED.
- `step`, output, 1 bit: registered one-cycle pulse, high in the cycle where `leds` shows a newly stepped value.

## Operation
- State: `active_mode` (2 bits), prescaler `cnt` (clog2(TICK_DIV) bits, minimum 1), `leds`, direction `dir` (0 = left, 1 = right).
- Reset (`reset_n` low at a clock edge) sets:
  - `active_mode` = CHASE
  - `cnt` = 0
  - `leds` = 1 (only bit 0 set)
  - `dir` = left
  - `step` = 0
- Reset overrides every other input, including during a pattern.
- Tick: internal `tick` = `enable` && (`cnt` == TICK_DIV-1).
  - With `enable` high, `cnt` increments and wraps to 0 on `tick`.
  - With `enable` low, `cnt` and `leds` hold and `step` = 0.
- Mode change has priority over tick.
  - When `mode` != `active_mode` at a clock edge, the block loads `active_mode` = `mode`, `cnt` = 0, `dir` = left and `leds` = the initial value of the new mode.
  - `step` = 0 on that edge.
  - This happens regardless of `enable`.
- Initial values: CHASE 1; BOUNCE 1; BLINK all ones; FILL 1.
- On `tick`, with no mode change, `leds` advances one step and `step` is high on the following cycle:
  - CHASE: rotate left by one; the MSB wraps to bit 0.
  - BOUNCE: shift one position in `dir`.
    - Reaching bit NUM_LEDS-1 sets `dir` = right.
    - Reaching bit 0 sets `dir` = left.
    - The end LEDs are lit for one step only; there is no double dwell.
  - BLINK: bitwise invert; all ones and all zeros alternate.
  - FILL: if `leds` is all ones, go to all zeros. Otherwise `leds` = (`leds` << 1) | 1. Period is NUM_LEDS+1 steps (0001→0011→0111→1111→0000→0001 for 4 LEDs).
- `leds` always shows a legal pattern for `active_mode`. No illegal encoding is reachable.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- Step latency: with `enable` held high from the first cycle after reset release, `leds` first changes after the TICK_DIV-th rising edge. Subsequent changes come every TICK_DIV edges.
- `step` rises on the same edge that updates `leds` and lasts exactly 1 cycle. With TICK_DIV=1 it stays high continuously while enabled.
- Mode change: new initial value on `leds` one edge after `mode` changes. The first step of the new mode follows TICK_DIV enabled edges later.
- Enable low for k cycles stretches the current step by exactly k cycles.

## Structure
- Package `led_pattern_pkg` holds:
  - mode constants/enum `MODE_CHASE`=0, `MODE_BOUNCE`=1, `MODE_BLINK`=2, `MODE_FILL`=3
  - direction constants `DIR_LEFT` and `DIR_RIGHT`
- One sub-module, `led_tick_gen` (parameter TICK_DIV; ports clk, reset_n, enable, clear, tick), contains the prescaler. `clear` is driven by the mode-change detect.
- The pattern next-state logic is a single case on `active_mode` in `led_pattern_fsm`.

## Test plan
All scenarios use NUM_LEDS=4, TICK_DIV=4, `clk` period 20 ns.
- Reset then CHASE, `enable`=1: `leds`=0001 after reset, 0010 after the 4th edge, then 0100, 1000, 0001 (wrap). `step` pulses once per 4 cycles.
- BOUNCE: sequence 0001,0010,0100,1000,0100,0010,0001,0010. No repeated end value.
- BLINK, then FILL: BLINK gives 1111,0000,1111. Switching to FILL gives 0001 on the next edge, then 0011,0111,1111,0000,0001.
- Freeze: in CHASE at 0100, hold `enable`=0 for 10 cycles. `leds` stays 0100 and `step` stays 0. After re-enable, 1000 appears exactly 10 cycles later than it would without the freeze.
- Mode change while disabled and reset mid-pattern:
  - `mode`→BLINK with `enable`=0: `leds`=1111 on the next edge and then holds.
  - `reset_n`=0 for one edge in FILL at 0111: `leds`=0001, `active_mode`=CHASE, `step`=0.
- TICK_DIV=1, NUM_LEDS=8 CHASE: `leds` rotates every cycle through all 8 positions and `step` stays high.

Source files
------------

// File: rtl/led_pattern_pkg.sv
// Shared mode and direction encodings for the LED pattern sequencer.
package led_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_CHASE  = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_FILL   = 2'd3
    } mode_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Prescaler width: clog2 of the divider, never narrower than one bit.
    function automatic int unsigned cnt_width(int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/led_pattern_fsm_if.sv
// Host-side control and LED drive bundle for led_pattern_fsm.
interface led_pattern_fsm_if #(
    parameter int unsigned NUM_LEDS = 4
);
    logic [1:0]          mode;
    logic                enable;
    logic [NUM_LEDS-1:0] leds;
    logic                step;

    modport master (output mode, output enable, input leds, input step);
    modport slave (input mode, input enable, output leds, output step);
endinterface

// File: rtl/led_tick_gen.sv
// Step-rate prescaler: pulses tick every TICK_DIV enabled cycles; clear restarts the count.
module led_tick_gen
    import led_pattern_pkg::*;
#(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);
    localparam int unsigned CntW = cnt_width(TICK_DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] cnt_q;

    assign tick = enable && (cnt_q == CntMax);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= tick ? '0 : cnt_q + CntW'(1);
        end
    end
endmodule

// File: rtl/led_pattern_fsm.sv
// LED pattern sequencer: chase, bounce, blink and fill patterns stepped by a prescaled tick.
module led_pattern_fsm
    import led_pattern_pkg::*;
#(
    parameter int unsigned NUM_LEDS = 4,
    parameter int unsigned TICK_DIV = 4
) (
    input logic              clk,
    input logic              reset_n,
    led_pattern_fsm_if.slave bus
);
    mode_e               active_mode_q, active_mode_d;
    logic                dir_q, dir_d;
    logic [NUM_LEDS-1:0] leds_q, leds_d;
    logic                step_q, step_d;
    mode_e               mode_in;
    logic                mode_change;
    logic                tick;

    assign mode_in     = mode_e'(bus.mode);
    assign mode_change = (mode_in != active_mode_q);

    function automatic logic [NUM_LEDS-1:0] init_leds(mode_e m);
        return (m == MODE_BLINK) ? '1 : NUM_LEDS'(1);
    endfunction

    led_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .reset_n(reset_n),
        .enable (bus.enable),
        .clear  (mode_change),
        .tick   (tick)
    );

    always_comb begin
        active_mode_d = active_mode_q;
        dir_d         = dir_q;
        leds_d        = leds_q;
        step_d        = 1'b0;
        // A mode change wins over a coincident tick and is never shown as a step.
        if (mode_change) begin
            active_mode_d = mode_in;
            dir_d         = DIR_LEFT;
            leds_d        = init_leds(mode_in);
        end else if (tick) begin
            step_d = 1'b1;
            unique case (active_mode_q)
                MODE_CHASE: leds_d = {leds_q[NUM_LEDS-2:0], leds_q[NUM_LEDS-1]};
                MODE_BOUNCE: begin
                    // Turn around on the step that reaches an end: single dwell at each end.
                    if (dir_q == DIR_LEFT) begin
                        leds_d = leds_q << 1;
                        if (leds_d[NUM_LEDS-1]) dir_d = DIR_RIGHT;
                    end else begin
                        leds_d = leds_q >> 1;
                        if (leds_d[0]) dir_d = DIR_LEFT;
                    end
                end
                MODE_BLINK: leds_d = ~leds_q;
                MODE_FILL:  leds_d = (&leds_q) ? '0 : {leds_q[NUM_LEDS-2:0], 1'b1};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            active_mode_q <= MODE_CHASE;
            dir_q         <= DIR_LEFT;
            leds_q        <= NUM_LEDS'(1);
            step_q        <= 1'b0;
        end else begin
            active_mode_q <= active_mode_d;
            dir_q         <= dir_d;
            leds_q        <= leds_d;
            step_q        <= step_d;
        end
    end

    assign bus.leds = leds_q;
    assign bus.step = step_q;
endmodule

// File: tb/tb_led_pattern_fsm.sv
// Scoreboard bench for led_pattern_fsm: 4-LED/div-4 and 8-LED/div-1 instances.
module tb_led_pattern_fsm;
    import led_pattern_pkg::*;

    typedef struct {
        logic [7:0] leds;
        logic       step;
        int         gap;   // cycles since previous leds change; 0 = not checked
    } exp_t;

    logic clk = 1'b0;
    logic reset_n1, reset_n2;
    always #10 clk = ~clk;

    led_pattern_fsm_if #(.NUM_LEDS(4)) bus1 ();
    led_pattern_fsm_if #(.NUM_LEDS(8)) bus2 ();

    led_pattern_fsm #(.NUM_LEDS(4), .TICK_DIV(4)) dut1 (
        .clk    (clk),
        .reset_n(reset_n1),
        .bus    (bus1)
    );

    led_pattern_fsm #(.NUM_LEDS(8), .TICK_DIV(1)) dut2 (
        .clk    (clk),
        .reset_n(reset_n2),
        .bus    (bus2)
    );

    exp_t q1[$];
    exp_t q2[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   probe_req1 = 0, probe_ack1 = 0, probe_req2 = 0, probe_ack2 = 0;
    bit   mon_en1 = 0, mon_en2 = 0;

    function automatic void check(string name, int got, int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
        end
    endfunction

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push1(logic [3:0] l, logic s, int g);
        exp_t e;
        e.leds = {4'b0, l};
        e.step = s;
        e.gap  = g;
        q1.push_back(e);
    endtask

    task automatic push2(logic [7:0] l, logic s, int g);
        exp_t e;
        e.leds = l;
        e.step = s;
        e.gap  = g;
        q2.push_back(e);
    endtask

    // Monitor for dut1: pops on any leds change, any step pulse, or an explicit probe.
    int         ncyc1 = 0, last1 = 0;
    logic [3:0] prev1 = '0;
    logic       chg1;
    exp_t       e1;
    always @(negedge clk) begin
        ncyc1++;
        chg1 = (bus1.leds != prev1);
        if (mon_en1 && (chg1 || bus1.step || probe_req1 != probe_ack1)) begin
            probe_ack1 = probe_req1;
            if (q1.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut1 unexpected output: leds=%b step=%b, expected nothing at %0t",
                         bus1.leds, bus1.step, $time);
            end else begin
                e1 = q1.pop_front();
                check("dut1 leds", int'(bus1.leds), int'(e1.leds));
                check("dut1 step", int'(bus1.step), int'(e1.step));
                if (chg1 && e1.gap != 0) check("dut1 step spacing", ncyc1 - last1, e1.gap);
            end
        end
        if (chg1) last1 = ncyc1;
        prev1 = bus1.leds;
    end

    int         ncyc2 = 0, last2 = 0;
    logic [7:0] prev2 = '0;
    logic       chg2;
    exp_t       e2;
    always @(negedge clk) begin
        ncyc2++;
        chg2 = (bus2.leds != prev2);
        if (mon_en2 && (chg2 || bus2.step || probe_req2 != probe_ack2)) begin
            probe_ack2 = probe_req2;
            if (q2.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut2 unexpected output: leds=%b step=%b, expected nothing at %0t",
                         bus2.leds, bus2.step, $time);
            end else begin
                e2 = q2.pop_front();
                check("dut2 leds", int'(bus2.leds), int'(e2.leds));
                check("dut2 step", int'(bus2.step), int'(e2.step));
                if (chg2 && e2.gap != 0) check("dut2 step spacing", ncyc2 - last2, e2.gap);
            end
        end
        if (chg2) last2 = ncyc2;
        prev2 = bus2.leds;
    end

    task automatic stim1();
        reset_n1    = 1'b0;
        bus1.enable = 1'b0;
        bus1.mode   = MODE_CHASE;
        cyc(2);
        push1(4'b0001, 1'b0, 0);
        probe_req1++;
        mon_en1     = 1;
        reset_n1    = 1'b1;
        bus1.enable = 1'b1;
        // CHASE with wrap
        push1(4'b0010, 1'b1, 0);
        push1(4'b0100, 1'b1, 4);
        push1(4'b1000, 1'b1, 4);
        push1(4'b0001, 1'b1, 4);
        cyc(16);
        // BOUNCE: initial 0001 is invisible, first step one cycle late
        bus1.mode = MODE_BOUNCE;
        push1(4'b0010, 1'b1, 5);
        push1(4'b0100, 1'b1, 4);
        push1(4'b1000, 1'b1, 4);
        push1(4'b0100, 1'b1, 4);
        push1(4'b0010, 1'b1, 4);
        push1(4'b0001, 1'b1, 4);
        push1(4'b0010, 1'b1, 4);
        cyc(29);
        bus1.mode = MODE_BLINK;
        push1(4'b1111, 1'b0, 1);
        push1(4'b0000, 1'b1, 4);
        push1(4'b1111, 1'b1, 4);
        cyc(9);
        bus1.mode = MODE_FILL;
        push1(4'b0001, 1'b0, 1);
        push1(4'b0011, 1'b1, 4);
        push1(4'b0111, 1'b1, 4);
        push1(4'b1111, 1'b1, 4);
        push1(4'b0000, 1'b1, 4);
        push1(4'b0001, 1'b1, 4);
        cyc(21);
        bus1.mode = MODE_CHASE;
        push1(4'b0010, 1'b1, 5);
        push1(4'b0100, 1'b1, 4);
        cyc(9);
        // Freeze for 10 cycles at 0100
        bus1.enable = 1'b0;
        cyc(5);
        push1(4'b0100, 1'b0, 0);
        probe_req1++;
        cyc(5);
        bus1.enable = 1'b1;
        push1(4'b1000, 1'b1, 14);
        cyc(4);
        // Mode change while disabled
        bus1.enable = 1'b0;
        bus1.mode   = MODE_BLINK;
        push1(4'b1111, 1'b0, 1);
        cyc(6);
        push1(4'b1111, 1'b0, 0);
        probe_req1++;
        // Reset mid-FILL at 0111
        bus1.enable = 1'b1;
        bus1.mode   = MODE_FILL;
        push1(4'b0001, 1'b0, 6);
        push1(4'b0011, 1'b1, 4);
        push1(4'b0111, 1'b1, 4);
        cyc(9);
        reset_n1 = 1'b0;
        push1(4'b0001, 1'b0, 1);
        cyc(1);
        reset_n1  = 1'b1;
        bus1.mode = MODE_CHASE;
        // No mode change after reset means active_mode came back as CHASE
        push1(4'b0010, 1'b1, 4);
        cyc(4);
        bus1.enable = 1'b0;
        cyc(3);
    endtask

    task automatic stim2();
        reset_n2    = 1'b0;
        bus2.enable = 1'b0;
        bus2.mode   = MODE_CHASE;
        cyc(2);
        push2(8'h01, 1'b0, 0);
        probe_req2++;
        mon_en2     = 1;
        reset_n2    = 1'b1;
        bus2.enable = 1'b1;
        push2(8'h02, 1'b1, 0);
        push2(8'h04, 1'b1, 1);
        push2(8'h08, 1'b1, 1);
        push2(8'h10, 1'b1, 1);
        push2(8'h20, 1'b1, 1);
        push2(8'h40, 1'b1, 1);
        push2(8'h80, 1'b1, 1);
        push2(8'h01, 1'b1, 1);
        push2(8'h02, 1'b1, 1);
        cyc(9);
        bus2.enable = 1'b0;
        cyc(3);
    endtask

    initial begin
        fork
            stim1();
            stim2();
        join
        cyc(2);
        check("dut1 expected outputs left unseen", q1.size(), 0);
        check("dut2 expected outputs left unseen", q2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
